vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 108 ++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// VGA sync generator: pixel/line counters with explicit horizontal and vertical region FSMs.
// Define VGA_FRAME_PULSE_EN to enable the one-clk frame_start pulse; otherwise it is tied to 0.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_start
);

  localparam logic [9:0] HActEnd  = 10'(H_ACTIVE - 1);
  localparam logic [9:0] HFpEnd   = 10'(H_ACTIVE + H_FP - 1);
  localparam logic [9:0] HSyncEnd = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] HLast    = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] VActEnd  = 10'(V_ACTIVE - 1);
  localparam logic [9:0] VFpEnd   = 10'(V_ACTIVE + V_FP - 1);
  localparam logic [9:0] VSyncEnd = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] VLast    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  typedef enum logic [1:0] {StActive, StFront, StSync, StBack} state_e;

  state_e     h_state_q, h_state_d, v_state_q, v_state_d;
  logic [9:0] h_cnt_d, v_cnt_d;
  logic       h_wrap, v_wrap;

  assign h_wrap = (h_cnt == HLast);
  assign v_wrap = (v_cnt == VLast);

  always_comb begin
    h_cnt_d   = h_cnt;
    v_cnt_d   = v_cnt;
    h_state_d = h_state_q;
    v_state_d = v_state_q;
    if (pix_en) begin
      h_cnt_d = h_wrap ? 10'd0 : h_cnt + 10'd1;
      unique case (h_state_q)
        StActive: if (h_cnt == HActEnd)  h_state_d = StFront;
        StFront:  if (h_cnt == HFpEnd)   h_state_d = StSync;
        StSync:   if (h_cnt == HSyncEnd) h_state_d = StBack;
        StBack:   if (h_wrap)            h_state_d = StActive;
        default:                         h_state_d = StActive;
      endcase
      if (h_wrap) begin
        v_cnt_d = v_wrap ? 10'd0 : v_cnt + 10'd1;
        unique case (v_state_q)
          StActive: if (v_cnt == VActEnd)  v_state_d = StFront;
          StFront:  if (v_cnt == VFpEnd)   v_state_d = StSync;
          StSync:   if (v_cnt == VSyncEnd) v_state_d = StBack;
          StBack:   if (v_wrap)            v_state_d = StActive;
          default:                         v_state_d = StActive;
        endcase
      end
    end
  end

  // Outputs are decoded from next state so they line up with the counters they accompany;
  // with pix_en low this re-registers the current state, which lets video_on rise right
  // after reset without disturbing the hold behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt     <= 10'd0;
      v_cnt     <= 10'd0;
      h_state_q <= StActive;
      v_state_q <= StActive;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
      video_on  <= 1'b0;
    end else begin
      h_cnt     <= h_cnt_d;
      v_cnt     <= v_cnt_d;
      h_state_q <= h_state_d;
      v_state_q <= v_state_d;
      hsync     <= (h_state_d != StSync);
      vsync     <= (v_state_d != StSync);
      video_on  <= (h_state_d == StActive) && (v_state_d == StActive);
    end
  end

`ifdef VGA_FRAME_PULSE_EN
  logic frame_start_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= pix_en && h_wrap && v_wrap;
    end
  end

  assign frame_start = frame_start_q;
`else
  assign frame_start = 1'b0;
`endif

endmodule
